// File: rtl/legv8_multicycle_control.sv
// Main control FSM for the multicycle LEGv8 datapath: opcode decode, state
// sequencing, datapath enables, retired-instruction count and illegal flag.
module legv8_multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic             pc_we,
  output logic             ior_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             reg2loc,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  localparam logic [3:0] S_INIT     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADDR  = 4'd3;
  localparam logic [3:0] S_MEMREAD  = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWRITE = 4'd6;
  localparam logic [3:0] S_EXEC     = 4'd7;
  localparam logic [3:0] S_RWB      = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;

  logic [3:0]       state_r;
  logic [3:0]       next_state_s;
  logic [CNT_W-1:0] retired_r;
  logic             illegal_r;
  logic             is_rtype_s;
  logic             is_ldur_s;
  logic             is_stur_s;
  logic             is_cbz_s;
  logic             is_b_s;
  logic             retire_s;
  logic             illegal_set_s;
  logic             unused_instr_s;

  assign is_rtype_s = (instr[31:21] == 11'b10001011000) ||
                      (instr[31:21] == 11'b11001011000) ||
                      (instr[31:21] == 11'b10001010000) ||
                      (instr[31:21] == 11'b10101010000);
  assign is_ldur_s  = (instr[31:21] == 11'b11111000010);
  assign is_stur_s  = (instr[31:21] == 11'b11111000000);
  assign is_cbz_s   = (instr[31:24] == 8'b10110100);
  assign is_b_s     = (instr[31:26] == 6'b000101);
  assign unused_instr_s = ^instr[20:0];

  // State register; reset lands in INIT so every decoded output is 0 at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_INIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; instr is only consulted from DECODE onward.
  always_comb begin
    next_state_s = S_INIT;
    case (state_r)
      S_INIT:     next_state_s = S_FETCH;
      S_FETCH:    next_state_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_ldur_s || is_stur_s) begin
          next_state_s = S_MEMADDR;
        end else if (is_rtype_s) begin
          next_state_s = S_EXEC;
        end else if (is_cbz_s) begin
          next_state_s = S_BRANCH;
        end else if (is_b_s) begin
          next_state_s = S_JUMP;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_MEMADDR: begin
        if (is_ldur_s) begin
          next_state_s = S_MEMREAD;
        end else if (is_stur_s) begin
          next_state_s = S_MEMWRITE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_MEMREAD:  next_state_s = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state_s = S_FETCH;
      S_MEMWRITE: next_state_s = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXEC:     next_state_s = S_RWB;
      S_RWB:      next_state_s = S_FETCH;
      S_BRANCH:   next_state_s = S_FETCH;
      S_JUMP:     next_state_s = S_FETCH;
      default:    next_state_s = S_INIT;
    endcase
  end

  // Illegal opcodes return to FETCH straight from DECODE, so they never retire.
  assign retire_s = (next_state_s == S_FETCH) &&
                    ((state_r == S_MEMWB) || (state_r == S_MEMWRITE) ||
                     (state_r == S_RWB)   || (state_r == S_BRANCH)   ||
                     (state_r == S_JUMP));
  assign illegal_set_s = (state_r == S_DECODE) && !(is_ldur_s || is_stur_s ||
                         is_rtype_s || is_cbz_s || is_b_s);

  // Retired-instruction counter (wraps) and sticky illegal-opcode flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_r <= {CNT_W{1'b0}};
      illegal_r <= 1'b0;
    end else begin
      if (retire_s) begin
        retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (illegal_set_s) begin
        illegal_r <= 1'b1;
      end
    end
  end

  // Moore output decode; FETCH and BRANCH qualify their PC write with inputs.
  always_comb begin
    alu_op     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    pc_we      = 1'b0;
    ior_d      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_we     = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        ior_d    = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        ior_d     = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB:      reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        pc_we     = zero;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_we     = 1'b1;
      end
      default: begin
        alu_op = 2'b00;
      end
    endcase
  end

  assign reg2loc = (state_r != S_INIT) && (is_stur_s || is_cbz_s);
  assign state   = state_r;
  assign retired = retired_r;
  assign illegal = illegal_r;

endmodule
